// File: rtl/gpio_bank_pkg.sv
// Shared constants for the AHB-Lite GPIO bank: register offsets within a port,
// port stride, and the AHB encodings the slave decodes.
package gpio_bank_pkg;

  localparam logic [4:0] OFF_OUT   = 5'h00;
  localparam logic [4:0] OFF_DIR   = 5'h04;
  localparam logic [4:0] OFF_IN    = 5'h08;
  localparam logic [4:0] OFF_SET   = 5'h0C;
  localparam logic [4:0] OFF_CLR   = 5'h10;
  localparam logic [4:0] OFF_TGL   = 5'h14;
  localparam logic [4:0] OFF_IEN   = 5'h18;
  localparam logic [4:0] OFF_ISTAT = 5'h1C;

  localparam int unsigned PORT_STRIDE = 32'h20;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/gpio_sync.sv
// Single-pin input synchroniser: SYNC_STAGES flops in series, cleared by HRESET.
module gpio_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/ahb_gpio_bank.sv
// Zero-wait AHB-Lite GPIO bank with per-pin direction and SET/CLR/TGL aliases.
// Define GPIO_EDGE_IRQ_EN to build the rising-edge interrupt logic (IEN/ISTAT/irq).
module ahb_gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int START_ADDR  = 0,
  parameter int NUM_PORTS   = 4,
  parameter int PORT_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [ADDR_WIDTH-1:0]            haddr,
  input  logic [DATA_WIDTH-1:0]            hwdata,
  output logic [DATA_WIDTH-1:0]            hrdata,
  input  logic                             hwrite,
  input  logic                             hsel,
  input  logic [1:0]                       htrans,
  input  logic [2:0]                       hsize,
  output logic                             hready,
  output logic                             hresp,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0]  gpio_oe,
  output logic                             irq
);

  localparam int NPINS = NUM_PORTS * PORT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BANK_SIZE = ADDR_WIDTH'(NUM_PORTS * PORT_STRIDE);

  logic [NPINS-1:0]      in_sync;
  logic [PORT_WIDTH-1:0] in_port [NUM_PORTS];

  for (genvar gi = 0; gi < NPINS; gi++) begin : g_sync
    gpio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .d      (gpio_in[gi]),
      .q      (in_sync[gi])
    );
  end

  logic [PORT_WIDTH-1:0] out_q [NUM_PORTS];
  logic [PORT_WIDTH-1:0] out_d [NUM_PORTS];
  logic [PORT_WIDTH-1:0] dir_q [NUM_PORTS];
  logic [PORT_WIDTH-1:0] dir_d [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign in_port[gi]                        = in_sync[gi*PORT_WIDTH +: PORT_WIDTH];
    assign gpio_out[gi*PORT_WIDTH +: PORT_WIDTH] = out_q[gi];
    assign gpio_oe[gi*PORT_WIDTH +: PORT_WIDTH]  = dir_q[gi];
  end

  // Address-phase decode and data-phase bookkeeping
  logic [ADDR_WIDTH-1:0] off;
  logic [2:0]            a_port;
  logic [4:0]            a_reg;
  logic                  a_active;
  logic                  a_legal;

  logic                  wr_pend_q, wr_pend_d;
  logic [2:0]            wr_port_q, wr_port_d;
  logic [4:0]            wr_reg_q,  wr_reg_d;
  logic                  hresp_q,   hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q,  hrdata_d;
  logic [PORT_WIDTH-1:0] wd;
  logic [PORT_WIDTH-1:0] rd_val;
  logic                  unused_hwdata;

  assign unused_hwdata = ^hwdata;
  assign wd            = hwdata[PORT_WIDTH-1:0];

`ifdef GPIO_EDGE_IRQ_EN
  logic [PORT_WIDTH-1:0] ien_q     [NUM_PORTS];
  logic [PORT_WIDTH-1:0] ien_d     [NUM_PORTS];
  logic [PORT_WIDTH-1:0] istat_q   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] istat_d   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] in_prev_q [NUM_PORTS];
  logic                  irq_q, irq_d;
`endif

  always_comb begin
    off      = haddr - BASE;
    a_port   = off[7:5];
    a_reg    = {off[4:2], 2'b00};
    a_active = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    a_legal  = (off < BANK_SIZE) && (hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00)
               && !(hwrite && (a_reg == OFF_IN));
  end

  // Next register state: the pending write commits this cycle, so reads decoded
  // now use these values and see the post-write contents.
  always_comb begin
`ifdef GPIO_EDGE_IRQ_EN
    irq_d = 1'b0;
`endif
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_d[p] = out_q[p];
      dir_d[p] = dir_q[p];
`ifdef GPIO_EDGE_IRQ_EN
      ien_d[p]   = ien_q[p];
      istat_d[p] = istat_q[p];
`endif
      if (wr_pend_q && (wr_port_q == 3'(p))) begin
        case (wr_reg_q)
          OFF_OUT: out_d[p] = wd;
          OFF_DIR: dir_d[p] = wd;
          OFF_SET: out_d[p] = out_q[p] | wd;
          OFF_CLR: out_d[p] = out_q[p] & ~wd;
          OFF_TGL: out_d[p] = out_q[p] ^ wd;
`ifdef GPIO_EDGE_IRQ_EN
          OFF_IEN:   ien_d[p]   = wd;
          OFF_ISTAT: istat_d[p] = istat_q[p] & ~wd;
`else
          OFF_IEN, OFF_ISTAT: ;
`endif
          default: ;
        endcase
      end
`ifdef GPIO_EDGE_IRQ_EN
      // Edge set is applied after the clear so a coincident edge wins.
      istat_d[p] = istat_d[p] | (in_port[p] & ~in_prev_q[p] & ien_q[p]);
      irq_d      = irq_d | (|(istat_q[p] & ien_q[p]));
`endif
    end
  end

  always_comb begin
    rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (a_port == 3'(p)) begin
        case (a_reg)
          OFF_OUT: rd_val = out_d[p];
          OFF_DIR: rd_val = dir_d[p];
          OFF_IN:  rd_val = in_port[p];
`ifdef GPIO_EDGE_IRQ_EN
          OFF_IEN:   rd_val = ien_d[p];
          OFF_ISTAT: rd_val = istat_d[p];
`else
          OFF_IEN, OFF_ISTAT: rd_val = '0;
`endif
          default: rd_val = '0;
        endcase
      end
    end
    hrdata_d  = (a_active && a_legal && !hwrite) ? DATA_WIDTH'(rd_val) : '0;
    hresp_d   = (a_active && !a_legal) ? HRESP_ERROR : HRESP_OKAY;
    wr_pend_d = a_active && a_legal && hwrite;
    wr_port_d = a_port;
    wr_reg_d  = a_reg;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_q <= 1'b0;
      wr_port_q <= '0;
      wr_reg_q  <= '0;
      hresp_q   <= HRESP_OKAY;
      hrdata_q  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p] <= '0;
        dir_q[p] <= '0;
`ifdef GPIO_EDGE_IRQ_EN
        ien_q[p]     <= '0;
        istat_q[p]   <= '0;
        in_prev_q[p] <= '0;
`endif
      end
`ifdef GPIO_EDGE_IRQ_EN
      irq_q <= 1'b0;
`endif
    end else begin
      wr_pend_q <= wr_pend_d;
      wr_port_q <= wr_port_d;
      wr_reg_q  <= wr_reg_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_q[p] <= out_d[p];
        dir_q[p] <= dir_d[p];
`ifdef GPIO_EDGE_IRQ_EN
        ien_q[p]     <= ien_d[p];
        istat_q[p]   <= istat_d[p];
        in_prev_q[p] <= in_port[p];
`endif
      end
`ifdef GPIO_EDGE_IRQ_EN
      irq_q <= irq_d;
`endif
    end
  end

  assign hready = 1'b1;
  assign hresp  = hresp_q;
  assign hrdata = hrdata_q;
`ifdef GPIO_EDGE_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
